// File: rtl/ila_capture_engine.sv
// ila_capture_engine: trigger-positioned capture into a circular sample buffer
// with a programmable pre-trigger window, per-channel trigger qualification,
// sample decimation and an arm/abort state machine.
module ila_capture_engine #(
  parameter int SIGNAL_W  = 32,
  parameter int TRIGGER_W = 4,
  parameter int BUFFER_W  = 8,
  parameter int DATA_W    = 32,
  localparam int NSLICE   = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int SEL_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [SIGNAL_W-1:0]   signal_i,
  input  logic [TRIGGER_W-1:0]  trigger_i,
  input  logic [TRIGGER_W-1:0]  trigger_mask_i,
  input  logic [TRIGGER_W-1:0]  trigger_negate_i,
  input  logic [TRIGGER_W-1:0]  trigger_edge_i,
  input  logic                  reduce_and_i,
  input  logic [BUFFER_W-1:0]   pretrig_i,
  input  logic [7:0]            decim_i,
  input  logic [BUFFER_W-1:0]   index_i,
  input  logic [SEL_W-1:0]      value_select_i,
  output logic [DATA_W-1:0]     value_o,
  output logic [2:0]            state_o,
  output logic                  done_o,
  output logic [BUFFER_W:0]     n_samples_o,
  output logic [BUFFER_W-1:0]   trig_addr_o
);

  localparam int DEPTH = 2 ** BUFFER_W;
  localparam logic [BUFFER_W:0] DEPTH_V = (BUFFER_W + 1)'(DEPTH);
  localparam int NSEL = 2 ** SEL_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SIGNAL_W-1:0]    sig_q, sig_d;
  logic [TRIGGER_W-1:0]   trig_q, trig_d;
  logic [TRIGGER_W-1:0]   x_prev_q, x_prev_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [BUFFER_W-1:0]    wptr_q, wptr_d;
  logic [BUFFER_W:0]      n_q, n_d;
  logic [BUFFER_W:0]      post_q, post_d;
  logic [BUFFER_W-1:0]    p_q, p_d;
  logic                   sticky_q, sticky_d;
  logic [BUFFER_W-1:0]    trig_addr_q, trig_addr_d;
  logic [SEL_W-1:0]       sel_q;
  logic [DATA_W-1:0]      value_q, value_d;
  logic [SIGNAL_W-1:0]    rd_data_q;
  logic [SIGNAL_W-1:0]    ram_q [DEPTH];
  logic                   we;

  // Trigger qualification: polarity, optional rising edge, masked reduction.
  logic [TRIGGER_W-1:0]   x, cond;
  logic                   hit_now, hit_any, strobe;
  logic [BUFFER_W:0]      post_target;

  assign x           = trig_q ^ trigger_negate_i;
  assign cond        = (x & ~trigger_edge_i) | (x & ~x_prev_q & trigger_edge_i);
  assign hit_now     = (trigger_mask_i != '0) &&
                       (reduce_and_i ? (&(cond | ~trigger_mask_i))
                                     : (|(cond & trigger_mask_i)));
  assign hit_any     = hit_now | sticky_q;
  assign strobe      = (cnt_q == 8'd0);
  // Samples still to be stored from the trigger sample onward.
  assign post_target = DEPTH_V - {1'b0, p_q};

  // Next-state logic for the capture FSM, counters and input registers.
  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    trig_d      = trig_q;
    x_prev_d    = x_prev_q;
    cnt_d       = cnt_q;
    wptr_d      = wptr_q;
    n_d         = n_q;
    post_d      = post_q;
    p_d         = p_q;
    sticky_d    = sticky_q;
    trig_addr_d = trig_addr_q;
    we          = 1'b0;
    if (cke_i) begin
      sig_d    = signal_i;
      trig_d   = trigger_i;
      x_prev_d = x;
      cnt_d    = (cnt_q >= decim_i) ? 8'd0 : cnt_q + 8'd1;
      sticky_d = strobe ? 1'b0 : (sticky_q | hit_now);
      if (abort_i) begin
        // Abort wins over everything, including a simultaneous arm.
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (arm_i) begin
              p_d      = pretrig_i;
              wptr_d   = '0;
              n_d      = '0;
              post_d   = '0;
              sticky_d = 1'b0;
              x_prev_d = '0;
              cnt_d    = 8'd0;
              state_d  = (pretrig_i != '0) ? ST_FILL : ST_WAIT;
            end
          end
          ST_FILL: begin
            // Pre-trigger fill ignores triggers entirely.
            sticky_d = 1'b0;
            if (strobe) begin
              we = 1'b1;
              if (n_q + (BUFFER_W + 1)'(1) == {1'b0, p_q}) state_d = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (strobe) begin
              we = 1'b1;
              if (hit_any) begin
                trig_addr_d = wptr_q;
                post_d      = (BUFFER_W + 1)'(1);
                state_d     = (post_target == (BUFFER_W + 1)'(1)) ? ST_DONE : ST_POST;
              end
            end
          end
          ST_POST: begin
            if (strobe) begin
              we     = 1'b1;
              post_d = post_q + (BUFFER_W + 1)'(1);
              if (post_q + (BUFFER_W + 1)'(1) == post_target) state_d = ST_DONE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
        if (we) begin
          wptr_d = wptr_q + 1'b1;
          n_d    = (n_q == DEPTH_V) ? n_q : n_q + (BUFFER_W + 1)'(1);
        end
      end
    end
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= ST_IDLE;
      sig_q       <= '0;
      trig_q      <= '0;
      x_prev_q    <= '0;
      cnt_q       <= 8'd0;
      wptr_q      <= '0;
      n_q         <= '0;
      post_q      <= '0;
      p_q         <= '0;
      sticky_q    <= 1'b0;
      trig_addr_q <= '0;
      sel_q       <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      trig_q      <= trig_d;
      x_prev_q    <= x_prev_d;
      cnt_q       <= cnt_d;
      wptr_q      <= wptr_d;
      n_q         <= n_d;
      post_q      <= post_d;
      p_q         <= p_d;
      sticky_q    <= sticky_d;
      trig_addr_q <= trig_addr_d;
      sel_q       <= value_select_i;
      value_q     <= value_d;
    end
  end

  // Logical-to-physical read address: oldest sample first once a capture is done.
  logic [BUFFER_W-1:0] start_addr, rd_addr;
  assign start_addr = (state_q == ST_DONE) ? (trig_addr_q - p_q) : '0;
  assign rd_addr    = start_addr + index_i;

  // Sample buffer: write port plus registered read, no reset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (we) ram_q[wptr_q] <= sig_q;
    rd_data_q <= ram_q[rd_addr];
  end

  // Slice table padded to a power of two so out-of-range selects read zero.
  logic [NSLICE*DATA_W-1:0] padded;
  logic [DATA_W-1:0]        slices [NSEL];
  assign padded = (NSLICE * DATA_W)'(rd_data_q);

  for (genvar gi = 0; gi < NSEL; gi++) begin : g_slice
    if (gi < NSLICE) begin : g_real
      assign slices[gi] = padded[gi*DATA_W +: DATA_W];
    end else begin : g_zero
      assign slices[gi] = '0;
    end
  end

  // Slice selection feeding the output register.
  always_comb begin
    value_d = slices[sel_q];
  end

  assign value_o     = value_q;
  assign state_o     = state_q;
  assign done_o      = (state_q == ST_DONE);
  assign n_samples_o = n_q;
  assign trig_addr_o = trig_addr_q;

endmodule
